// File: rtl/cpu_clk_pkg.sv
// Shared types, constants and phase-length helpers for the CPU clock generator.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        HIGH    = 2'd1,
        STRETCH = 2'd2,
        STOP    = 2'd3
    } clk_state_t;

    localparam int unsigned DIV_MIN     = 2;
    localparam int unsigned DIV_DEFAULT = 6;

    // Divisors below DIV_MIN cannot produce a one-cycle high and low phase.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    function automatic int unsigned high_len(input int unsigned d);
        return d / 2;
    endfunction

    function automatic int unsigned low_len(input int unsigned d);
        return d - (d / 2);
    endfunction

endpackage

// File: rtl/cpu_clk_phase_cnt.sv
// Loadable saturating down-counter; tc_c flags the final cycle of a loaded span.
module cpu_clk_phase_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A count of 0 or 1 means the current cycle is the last one.
    assign tc_c = (count <= W'(1));

endmodule

// File: rtl/cpu_clk_gen.sv
// PHI0 generator from CLK_SRC: run-time divisor, high-phase stretching, edge strobes.
// Optional static stop in the high phase when CPU_CLK_STOP_EN is defined.
module cpu_clk_gen #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = cpu_clk_pkg::DIV_DEFAULT,
    parameter int unsigned STR_W       = 4
) (
    input  logic             CLK_SRC,
    input  logic             RESET_N,
    input  logic [CNT_W-1:0] DIV_IN,
    input  logic             DIV_LOAD,
    input  logic             STRETCH_REQ,
    input  logic [STR_W-1:0] STRETCH_CNT,
`ifdef CPU_CLK_STOP_EN
    input  logic             CLK_STOP,
`endif
    output logic             PHI0,
    output logic             PHI0_RISE,
    output logic             PHI0_FALL,
    output logic [CNT_W-1:0] DIV_ACTIVE
);

    import cpu_clk_pkg::*;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(DIV_DEFAULT));

    clk_state_t       state, state_nx;
    logic [CNT_W-1:0] div_pend, div_act_nx;
    logic             str_arm, str_arm_nx;
    logic             str_sel, str_go, exit_high;
    logic             phi0_nx, rise_nx, fall_nx;
    logic             ph_load, ph_tc;
    logic [CNT_W-1:0] ph_val, ph_low;
    logic             st_load, st_en, st_tc;
    logic [STR_W-1:0] st_val;

    cpu_clk_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (CLK_SRC),
        .rst_n    (RESET_N),
        .load     (ph_load),
        .en       (1'b1),
        .load_val (ph_val),
        .tc_c     (ph_tc)
    );

    cpu_clk_phase_cnt #(.W(STR_W)) u_stretch_cnt (
        .clk      (CLK_SRC),
        .rst_n    (RESET_N),
        .load     (st_load),
        .en       (st_en),
        .load_val (st_val),
        .tc_c     (st_tc)
    );

    // Next-state, counter loads and next output values.
    always_comb begin
        state_nx   = state;
        div_act_nx = DIV_ACTIVE;
        ph_load    = 1'b0;
        ph_val     = '0;
        exit_high  = 1'b0;
        ph_low     = CNT_W'(low_len(32'(DIV_ACTIVE)));
        // Stretch request is only looked at during the rise cycle.
        str_sel    = STRETCH_REQ && (STRETCH_CNT != '0);
        str_go     = PHI0_RISE ? str_sel : str_arm;
        str_arm_nx = str_go;
        st_load    = PHI0_RISE;
        st_val     = str_sel ? STRETCH_CNT : '0;
        st_en      = (state == STRETCH);

        case (state)
            LOW: begin
                if (ph_tc) begin
                    state_nx   = HIGH;
                    div_act_nx = div_pend;
                    ph_load    = 1'b1;
                    ph_val     = CNT_W'(high_len(32'(div_pend)));
                end
            end
            HIGH: begin
                if (ph_tc) begin
                    if (str_go) begin
                        state_nx = STRETCH;
                    end else begin
                        exit_high = 1'b1;
                    end
                end
            end
            STRETCH: begin
                if (st_tc) begin
                    exit_high = 1'b1;
                end
            end
`ifdef CPU_CLK_STOP_EN
            STOP: begin
                if (!CLK_STOP) begin
                    state_nx = LOW;
                    ph_load  = 1'b1;
                    ph_val   = ph_low;
                end
            end
`endif
            default: begin
                state_nx = LOW;
            end
        endcase

        if (exit_high) begin
`ifdef CPU_CLK_STOP_EN
            if (CLK_STOP) begin
                state_nx = STOP;
            end else begin
                state_nx = LOW;
                ph_load  = 1'b1;
                ph_val   = ph_low;
            end
`else
            state_nx = LOW;
            ph_load  = 1'b1;
            ph_val   = ph_low;
`endif
        end

        phi0_nx = (state_nx != LOW);
        rise_nx = (state == LOW) && (state_nx == HIGH);
        fall_nx = (state != LOW) && (state_nx == LOW);
    end

    // State and registered outputs.
    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= LOW;
            str_arm    <= 1'b0;
            div_pend   <= DIV_RST;
            DIV_ACTIVE <= DIV_RST;
            PHI0       <= 1'b0;
            PHI0_RISE  <= 1'b0;
            PHI0_FALL  <= 1'b0;
        end else begin
            state      <= state_nx;
            str_arm    <= str_arm_nx;
            DIV_ACTIVE <= div_act_nx;
            PHI0       <= phi0_nx;
            PHI0_RISE  <= rise_nx;
            PHI0_FALL  <= fall_nx;
            if (DIV_LOAD) begin
                div_pend <= CNT_W'(clamp_div(32'(DIV_IN)));
            end
        end
    end

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Directed vector bench for cpu_clk_gen; covers the stop path when CPU_CLK_STOP_EN is defined.
module tb_cpu_clk_gen;

    logic       CLK_SRC;
    logic       RESET_N;
    logic [7:0] DIV_IN;
    logic       DIV_LOAD;
    logic       STRETCH_REQ;
    logic [3:0] STRETCH_CNT;
`ifdef CPU_CLK_STOP_EN
    logic       CLK_STOP;
`endif
    logic       PHI0;
    logic       PHI0_RISE;
    logic       PHI0_FALL;
    logic [7:0] DIV_ACTIVE;

    cpu_clk_gen dut (
        .CLK_SRC     (CLK_SRC),
        .RESET_N     (RESET_N),
        .DIV_IN      (DIV_IN),
        .DIV_LOAD    (DIV_LOAD),
        .STRETCH_REQ (STRETCH_REQ),
        .STRETCH_CNT (STRETCH_CNT),
`ifdef CPU_CLK_STOP_EN
        .CLK_STOP    (CLK_STOP),
`endif
        .PHI0        (PHI0),
        .PHI0_RISE   (PHI0_RISE),
        .PHI0_FALL   (PHI0_FALL),
        .DIV_ACTIVE  (DIV_ACTIVE)
    );

    typedef struct {
        logic       dl;
        logic [7:0] din;
        logic       sr;
        logic [3:0] sc;
        logic       phi;
        logic       rise;
        logic       fall;
        int         da;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial CLK_SRC = 1'b0;
    always #10 CLK_SRC = ~CLK_SRC;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One PHI0 period: h high cycles (rise on first), l low cycles (fall on first).
    task automatic add_period(input int h, input int l, input int da);
        vec_t v;
        for (int i = 0; i < h; i++) begin
            v = '{1'b0, 8'd0, 1'b0, 4'd0, 1'b1, (i == 0), 1'b0, da};
            vq.push_back(v);
        end
        for (int i = 0; i < l; i++) begin
            v = '{1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, (i == 0), da};
            vq.push_back(v);
        end
    endtask

    task automatic set_load(input int idx, input int val);
        vq[idx].dl  = 1'b1;
        vq[idx].din = 8'(val);
    endtask

    task automatic set_str(input int idx, input logic req, input int cnt);
        vq[idx].sr = req;
        vq[idx].sc = 4'(cnt);
    endtask

    task automatic wait_rise(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge CLK_SRC);
            #1;
            if (PHI0_RISE) seen = 1'b1;
        end
        chk(nm, int'(seen), 1);
    endtask

    initial begin
        int b;
        RESET_N     = 1'b0;
        DIV_IN      = 8'd0;
        DIV_LOAD    = 1'b0;
        STRETCH_REQ = 1'b0;
        STRETCH_CNT = 4'd0;
`ifdef CPU_CLK_STOP_EN
        CLK_STOP    = 1'b0;
`endif

        // Inputs of vector k are sampled by the edge whose result vector k expects.
        add_period(3, 3, 6);
        b = vq.size(); add_period(3, 3, 6);  set_load(b + 1, 5);
        b = vq.size(); add_period(2, 3, 5);  set_load(b + 4, 2);
        add_period(1, 1, 2);
        b = vq.size(); add_period(1, 1, 2);  set_load(b, 4);
        b = vq.size(); add_period(2, 2, 4);  set_load(b, 1);
        b = vq.size(); add_period(1, 1, 2);  set_load(b, 6);
        b = vq.size(); add_period(3, 3, 6);  set_load(b + 1, 10);
        b = vq.size(); add_period(5, 5, 10); set_load(b, 6);
        b = vq.size(); add_period(7, 3, 6);  set_str(b + 1, 1'b1, 4);
        add_period(3, 3, 6);
        b = vq.size(); add_period(3, 3, 6);  set_str(b + 2, 1'b1, 4);
        b = vq.size(); add_period(3, 3, 6);  set_str(b + 1, 1'b1, 0);
        b = vq.size(); add_period(5, 3, 6);  set_str(b + 1, 1'b1, 2); set_str(b + 2, 1'b1, 9);

        repeat (3) @(posedge CLK_SRC);
        #1;
        chk("reset phi0", int'(PHI0), 0);
        chk("reset rise", int'(PHI0_RISE), 0);
        chk("reset fall", int'(PHI0_FALL), 0);
        chk("reset div_active", int'(DIV_ACTIVE), 6);
        @(negedge CLK_SRC);
        RESET_N = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            DIV_LOAD    = vq[i].dl;
            DIV_IN      = vq[i].din;
            STRETCH_REQ = vq[i].sr;
            STRETCH_CNT = vq[i].sc;
            @(posedge CLK_SRC);
            #1;
            chk($sformatf("vec%0d phi0", i), int'(PHI0), int'(vq[i].phi));
            chk($sformatf("vec%0d rise", i), int'(PHI0_RISE), int'(vq[i].rise));
            chk($sformatf("vec%0d fall", i), int'(PHI0_FALL), int'(vq[i].fall));
            chk($sformatf("vec%0d div_active", i), int'(DIV_ACTIVE), vq[i].da);
        end
        DIV_LOAD    = 1'b0;
        STRETCH_REQ = 1'b0;
        STRETCH_CNT = 4'd0;

        // Reset asserted mid-stretch with a non-default divisor in effect.
        DIV_LOAD = 1'b1;
        DIV_IN   = 8'd4;
        @(posedge CLK_SRC);
        #1;
        DIV_LOAD = 1'b0;
        chk("boundary load keeps div", int'(DIV_ACTIVE), 6);
        wait_rise("rise with div 4");
        chk("div_active 4", int'(DIV_ACTIVE), 4);
        STRETCH_REQ = 1'b1;
        STRETCH_CNT = 4'd5;
        @(posedge CLK_SRC);
        #1;
        STRETCH_REQ = 1'b0;
        STRETCH_CNT = 4'd0;
        repeat (2) @(posedge CLK_SRC);
        #1;
        chk("stretch phi0", int'(PHI0), 1);
        chk("stretch no fall", int'(PHI0_FALL), 0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async reset phi0", int'(PHI0), 0);
        chk("async reset rise", int'(PHI0_RISE), 0);
        chk("async reset fall", int'(PHI0_FALL), 0);
        chk("async reset div_active", int'(DIV_ACTIVE), 6);
        @(negedge CLK_SRC);
        RESET_N = 1'b1;
        @(posedge CLK_SRC);
        #1;
        chk("post reset rise", int'(PHI0_RISE), 1);
        chk("post reset phi0", int'(PHI0), 1);

`ifdef CPU_CLK_STOP_EN
        // CLK_STOP held for 20 cycles parks PHI0 high after the high phase.
        @(negedge CLK_SRC);
        RESET_N  = 1'b0;
        CLK_STOP = 1'b1;
        @(negedge CLK_SRC);
        RESET_N  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK_SRC);
            #1;
            chk($sformatf("stop%0d phi0", k), int'(PHI0), 1);
            chk($sformatf("stop%0d rise", k), int'(PHI0_RISE), (k == 1) ? 1 : 0);
            chk($sformatf("stop%0d fall", k), int'(PHI0_FALL), 0);
        end
        CLK_STOP = 1'b0;
        @(posedge CLK_SRC);
        #1;
        chk("stop release phi0", int'(PHI0), 0);
        chk("stop release fall", int'(PHI0_FALL), 1);
        @(posedge CLK_SRC);
        #1;
        chk("stop release low", int'(PHI0), 0);
        chk("stop release fall once", int'(PHI0_FALL), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
